// File: rtl/mem_arb_pkg.sv
// Shared definitions for the memory arbiter: FSM state encodings, word size
// and a constant-evaluable clog2 helper.
package mem_arb_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FILL,
    DRAIN,
    WRITE,
    WWAIT
  } arb_state_t;

  localparam int unsigned WORD_BYTES = 2;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester at or after the pointer,
// wrapping at NUM_PORTS; returns one-hot winner, its index and a valid flag.
module rr_arbiter #(
  parameter int unsigned NUM_PORTS = 2,
  parameter int unsigned PTR_W     = 1
) (
  input  logic [NUM_PORTS-1:0] req,
  input  logic [PTR_W-1:0]     ptr,
  output logic [NUM_PORTS-1:0] grant,
  output logic [PTR_W-1:0]     idx,
  output logic                 valid
);

  int unsigned cand;

  always_comb begin
    grant = '0;
    idx   = '0;
    valid = 1'b0;
    cand  = 0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      cand = (32'(ptr) + i) % NUM_PORTS;
      for (int unsigned j = 0; j < NUM_PORTS; j++) begin
        if (j == cand && !valid && req[j]) begin
          grant[j] = 1'b1;
          idx      = PTR_W'(j);
          valid    = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter and block-transfer engine between cache clients and one
// multi-cycle memory. Define CRIT_WORD_FIRST_EN for critical-word-first fills.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned NUM_PORTS       = 2,
  parameter int unsigned ADDR_W          = 16,
  parameter int unsigned DATA_W          = 16,
  parameter int unsigned WORDS_PER_BLOCK = 8,
  parameter int unsigned MEM_LAT         = 4
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [NUM_PORTS-1:0]                 req,
  input  logic [NUM_PORTS-1:0]                 wr,
  input  logic [NUM_PORTS*ADDR_W-1:0]          addr,
  input  logic [NUM_PORTS*DATA_W-1:0]          wdata,
  output logic [NUM_PORTS-1:0]                 gnt,
  output logic [NUM_PORTS-1:0]                 rvalid,
  output logic [DATA_W-1:0]                    rdata,
  output logic [clog2(WORDS_PER_BLOCK)-1:0]    rword,
  output logic [NUM_PORTS-1:0]                 done,
  output logic                                 mem_enable,
  output logic                                 mem_wr,
  output logic [ADDR_W-1:0]                    mem_addr,
  output logic [DATA_W-1:0]                    mem_wdata,
  input  logic [DATA_W-1:0]                    mem_rdata,
  input  logic                                 mem_data_valid
);

  localparam int unsigned IDX_W = clog2(WORDS_PER_BLOCK);
  localparam int unsigned CNT_W = IDX_W + 1;
  localparam int unsigned OFF_W = IDX_W + clog2(WORD_BYTES);
  localparam int unsigned PTR_W = (NUM_PORTS > 1) ? clog2(NUM_PORTS) : 1;
  localparam int unsigned LAT_W = clog2(MEM_LAT + 1);
  localparam logic [CNT_W-1:0]  LAST     = CNT_W'(WORDS_PER_BLOCK - 1);
  localparam logic [LAT_W-1:0]  WW_LAST  = LAT_W'((MEM_LAT > 1) ? MEM_LAT - 2 : 0);
  localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'((64'd1 << OFF_W) - 1);

  arb_state_t state_q, state_d;
  logic [NUM_PORTS-1:0] gnt_q, win_oh;
  logic [PTR_W-1:0]     ptr_q, win_idx;
  logic                 win_valid;
  logic [ADDR_W-1:0]    addr_q, sel_addr, blk_base;
  logic [DATA_W-1:0]    wdata_q, sel_wdata;
  logic                 sel_wr;
  logic [IDX_W-1:0]     start_q, start_d, iss_word, ret_word;
  logic [CNT_W-1:0]     icnt_q, rcnt_q;
  logic [LAT_W-1:0]     wcnt_q;
  logic                 fill_act, ret, last_ret, last_iss, wr_done;

  rr_arbiter #(
    .NUM_PORTS (NUM_PORTS),
    .PTR_W     (PTR_W)
  ) u_rr (
    .req   (req),
    .ptr   (ptr_q),
    .grant (win_oh),
    .idx   (win_idx),
    .valid (win_valid)
  );

  always_comb begin : port_mux
    sel_addr  = '0;
    sel_wdata = '0;
    sel_wr    = 1'b0;
    for (int unsigned p = 0; p < NUM_PORTS; p++) begin
      if (win_oh[p]) begin
        sel_addr  = addr[p*ADDR_W +: ADDR_W];
        sel_wdata = wdata[p*DATA_W +: DATA_W];
        sel_wr    = wr[p];
      end
    end
  end

`ifdef CRIT_WORD_FIRST_EN
  assign start_d = sel_addr[OFF_W-1 -: IDX_W];
`else
  assign start_d = '0;
`endif

  // Word indices wrap naturally inside IDX_W bits, keeping fills within the block.
  assign iss_word = start_q + icnt_q[IDX_W-1:0];
  assign ret_word = start_q + rcnt_q[IDX_W-1:0];
  assign blk_base = addr_q & ~OFF_MASK;

  assign fill_act = (state_q == FILL) || (state_q == DRAIN);
  assign ret      = fill_act && mem_data_valid;
  assign last_ret = ret && (rcnt_q == LAST);
  assign last_iss = (state_q == FILL) && (icnt_q == LAST);
  assign wr_done  = ((state_q == WRITE) && (MEM_LAT == 1)) ||
                    ((state_q == WWAIT) && (wcnt_q == WW_LAST));

  always_comb begin : fsm_next
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (win_valid) state_d = sel_wr ? WRITE : FILL;
      FILL:    if (last_iss) state_d = last_ret ? IDLE : DRAIN;
      DRAIN:   if (last_ret) state_d = IDLE;
      WRITE:   state_d = (MEM_LAT > 1) ? WWAIT : IDLE;
      WWAIT:   if (wcnt_q == WW_LAST) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin : mem_drive
    mem_enable = 1'b0;
    mem_wr     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    case (state_q)
      FILL: begin
        mem_enable = 1'b1;
        mem_addr   = blk_base + ADDR_W'(iss_word) * ADDR_W'(WORD_BYTES);
      end
      WRITE: begin
        mem_enable = 1'b1;
        mem_wr     = 1'b1;
        mem_addr   = addr_q;
        mem_wdata  = wdata_q;
      end
      default: ;
    endcase
  end

  assign gnt    = gnt_q;
  assign rvalid = ret ? gnt_q : '0;
  assign rdata  = ret ? mem_rdata : '0;
  assign rword  = ret ? ret_word : '0;
  assign done   = (last_ret || wr_done) ? gnt_q : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      ptr_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      start_q <= '0;
      icnt_q  <= '0;
      rcnt_q  <= '0;
      wcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      if (state_d == IDLE) gnt_q <= '0;
      case (state_q)
        IDLE: begin
          if (win_valid) begin
            gnt_q   <= win_oh;
            ptr_q   <= (win_idx == PTR_W'(NUM_PORTS - 1)) ? '0 : win_idx + PTR_W'(1);
            addr_q  <= sel_addr;
            wdata_q <= sel_wdata;
            start_q <= start_d;
            icnt_q  <= '0;
            rcnt_q  <= '0;
            wcnt_q  <= '0;
          end
        end
        FILL: begin
          icnt_q <= icnt_q + CNT_W'(1);
          if (ret) rcnt_q <= rcnt_q + CNT_W'(1);
        end
        DRAIN:   if (ret) rcnt_q <= rcnt_q + CNT_W'(1);
        WWAIT:   wcnt_q <= wcnt_q + LAT_W'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: stimulus pushes expected grants, memory
// issues, fill returns and write completions; a negedge monitor pops and compares.
module tb_mem_arbiter;

  localparam int unsigned NP  = 2;
  localparam int unsigned AW  = 16;
  localparam int unsigned DW  = 16;
  localparam int unsigned WPB = 8;
  localparam int unsigned LAT = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NP-1:0]     req = '0;
  logic [NP-1:0]     wr  = '0;
  logic [NP*AW-1:0]  addr  = '0;
  logic [NP*DW-1:0]  wdata = '0;
  logic [NP-1:0]     gnt, rvalid, done;
  logic [DW-1:0]     rdata;
  logic [2:0]        rword;
  logic              mem_enable, mem_wr;
  logic [AW-1:0]     mem_addr;
  logic [DW-1:0]     mem_wdata, mem_rdata;
  logic              mem_data_valid;

  always #5 clk = ~clk;

  mem_arbiter #(
    .NUM_PORTS       (NP),
    .ADDR_W          (AW),
    .DATA_W          (DW),
    .WORDS_PER_BLOCK (WPB),
    .MEM_LAT         (LAT)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .req            (req),
    .wr             (wr),
    .addr           (addr),
    .wdata          (wdata),
    .gnt            (gnt),
    .rvalid         (rvalid),
    .rdata          (rdata),
    .rword          (rword),
    .done           (done),
    .mem_enable     (mem_enable),
    .mem_wr         (mem_wr),
    .mem_addr       (mem_addr),
    .mem_wdata      (mem_wdata),
    .mem_rdata      (mem_rdata),
    .mem_data_valid (mem_data_valid)
  );

  // Memory: read data returns 4 cycles after issue, mem[a] = a ^ 16'hA5A5.
  logic [3:0]         pv = '0;
  logic [3:0][AW-1:0] pa = '0;
  always @(posedge clk) begin
    pv <= {pv[2:0], mem_enable & ~mem_wr};
    pa <= {pa[2:0], mem_addr};
  end
  assign mem_data_valid = pv[3];
  assign mem_rdata      = pa[3] ^ 16'hA5A5;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed { int unsigned cyc; logic [NP-1:0] val; } gnt_ev_t;
  typedef struct packed { int unsigned cyc; logic w; logic [AW-1:0] a; logic [DW-1:0] d; } iss_ev_t;
  typedef struct packed { int unsigned cyc; int unsigned port; logic [DW-1:0] d; logic [2:0] word; logic last; } ret_ev_t;
  typedef struct packed { int unsigned cyc; int unsigned port; } done_ev_t;

  gnt_ev_t     gq[$];
  iss_ev_t     iq[$];
  ret_ev_t     rq[$];
  done_ev_t    dq[$];
  int unsigned zq[$];

  int unsigned checks = 0;
  int unsigned failures = 0;
  int unsigned tmo_cnt = 0;
  logic        mon_en = 1'b0;
  logic        tb_end = 1'b0;

  // s = cycle in which the DUT first sees the request; abort_at = relative cycle a reset kills it.
  function automatic void push_fill(input int unsigned p, input logic [AW-1:0] a,
                                    input int unsigned s, input int unsigned abort_at);
    logic [AW-1:0] base, wa;
    logic [2:0]    st, w;
    int unsigned   endc;
    base = a & 16'hFFF0;
`ifdef CRIT_WORD_FIRST_EN
    st = a[3:1];
`else
    st = 3'd0;
`endif
    endc = (abort_at != 0) ? abort_at : 13;
    gq.push_back(gnt_ev_t'{s + 1, NP'(1 << p)});
    for (int unsigned i = 0; i < WPB; i++) begin
      w  = st + 3'(i);
      wa = base + {12'h000, w, 1'b0};
      if (1 + i < endc) iq.push_back(iss_ev_t'{s + 1 + i, 1'b0, wa, 16'h0000});
      if (5 + i < endc) rq.push_back(ret_ev_t'{s + 5 + i, p, wa ^ 16'hA5A5, w, (i == WPB - 1)});
    end
    gq.push_back(gnt_ev_t'{s + endc, '0});
  endfunction

  function automatic void push_write(input int unsigned p, input logic [AW-1:0] a,
                                     input logic [DW-1:0] d, input int unsigned s);
    gq.push_back(gnt_ev_t'{s + 1, NP'(1 << p)});
    iq.push_back(iss_ev_t'{s + 1, 1'b1, a, d});
    dq.push_back(done_ev_t'{s + LAT, p});
    gq.push_back(gnt_ev_t'{s + LAT + 1, '0});
  endfunction

  task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s @cyc %0d: got=%h exp=%h", nm, cyc, got, exp);
    end
  endtask

  task automatic unexpected(input string nm);
    checks++;
    failures++;
    $display("FAIL %s_unexpected @cyc %0d: gnt=%b rvalid=%b done=%b mem_en=%b addr=%h",
             nm, cyc, gnt, rvalid, done, mem_enable, mem_addr);
  endtask

  // Monitor / scoreboard
  initial begin : monitor
    logic [NP-1:0] gprev;
    gnt_ev_t  ge;
    iss_ev_t  ie;
    ret_ev_t  re;
    done_ev_t de;
    gprev = '0;
    forever begin
      @(negedge clk);
      if (tb_end) break;
      if (mon_en) begin
        if (gnt !== gprev) begin
          if (gq.size() == 0) unexpected("gnt");
          else begin
            ge = gq.pop_front();
            chk("gnt", {cyc, gnt}, {ge.cyc, ge.val});
          end
        end
        gprev = gnt;
        if (mem_enable !== 1'b0) begin
          if (iq.size() == 0) unexpected("issue");
          else begin
            ie = iq.pop_front();
            chk("issue", {cyc, mem_enable, mem_wr, mem_addr, (ie.w ? mem_wdata : 16'h0000)},
                         {ie.cyc, 1'b1, ie.w, ie.a, ie.d});
          end
        end
        if (rvalid !== '0) begin
          if (rq.size() == 0) unexpected("ret");
          else begin
            re = rq.pop_front();
            chk("ret", {cyc, rvalid, rdata, rword, done},
                       {re.cyc, NP'(1 << re.port), re.d, re.word, (re.last ? NP'(1 << re.port) : NP'(0))});
          end
        end else if (done !== '0) begin
          if (dq.size() == 0) unexpected("done");
          else begin
            de = dq.pop_front();
            chk("wdone", {cyc, done}, {de.cyc, NP'(1 << de.port)});
          end
        end
        if (zq.size() > 0 && zq[0] == cyc) begin
          void'(zq.pop_front());
          chk("all_zero", {gnt, rvalid, rdata, rword, done, mem_enable, mem_wr, mem_addr, mem_wdata}, '0);
        end
      end
    end
    chk("queues_empty", 128'(gq.size() + iq.size() + rq.size() + dq.size() + zq.size()), '0);
    chk("timeouts", 128'(tmo_cnt), '0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1);
  end

  task automatic adv(input int unsigned n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive(input int unsigned p, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req[p]              = 1'b1;
    wr[p]               = w;
    addr[p*AW +: AW]    = a;
    wdata[p*DW +: DW]   = d;
  endtask

  // Drops each port's req in the cycle after its done pulse.
  task automatic wait_done(input logic [NP-1:0] mask);
    logic [NP-1:0] pend, d;
    int unsigned   n;
    pend = mask;
    n    = 0;
    while (pend != '0 && n < 100) begin
      @(negedge clk);
      n++;
      d = done & pend;
      @(posedge clk);
      #1;
      req  = req & ~d;
      pend = pend & ~d;
    end
    if (pend != '0) begin
      tmo_cnt++;
      req = '0;
    end
  endtask

  initial begin : stimulus
    int unsigned s;
    adv(3);
    rst    = 1'b0;
    mon_en = 1'b1;
    zq.push_back(cyc);
    adv(2);

    // Port0 fill 0x0040
    adv(1); s = cyc;
    push_fill(0, 16'h0040, s, 0);
    zq.push_back(s + 13);
    drive(0, 1'b0, 16'h0040, 16'h0000);
    wait_done(2'b01); adv(3);

    // Port1 write-through 0x1234 <- 0xBEEF
    adv(1); s = cyc;
    push_write(1, 16'h1234, 16'hBEEF, s);
    drive(1, 1'b1, 16'h1234, 16'hBEEF);
    wait_done(2'b10); adv(3);

    // Both request: port0 fill first, port1 write after the idle cycle
    adv(1); s = cyc;
    push_fill(0, 16'h0100, s, 0);
    push_write(1, 16'h2222, 16'h5A5A, s + 13);
    drive(0, 1'b0, 16'h0100, 16'h0000);
    drive(1, 1'b1, 16'h2222, 16'h5A5A);
    wait_done(2'b11); adv(3);

    // Next pair grants port0 again; port1 fill near the top of memory
    adv(1); s = cyc;
    push_write(0, 16'h0010, 16'h0F0F, s);
    push_fill(1, 16'hFFF6, s + 5, 0);
    drive(0, 1'b1, 16'h0010, 16'h0F0F);
    drive(1, 1'b0, 16'hFFF6, 16'h0000);
    wait_done(2'b11); adv(3);

    // Unaligned fill address 0x004A
    adv(1); s = cyc;
    push_fill(0, 16'h004A, s, 0);
    drive(0, 1'b0, 16'h004A, 16'h0000);
    wait_done(2'b01); adv(3);

    // req0 dropped and port inputs changed mid-fill: transfer completes unchanged
    adv(1); s = cyc;
    push_fill(0, 16'h0080, s, 0);
    drive(0, 1'b0, 16'h0080, 16'h0000);
    adv(3);
    req[0]       = 1'b0;
    wr[0]        = 1'b1;
    addr[AW-1:0] = 16'hDEAD;
    wait_done(2'b01); adv(3);
    wr[0] = 1'b0;

    // Reset during a fill: outputs clear next cycle, late returns are ignored
    adv(1); s = cyc;
    push_fill(0, 16'h0200, s, 7);
    zq.push_back(s + 7);
    drive(0, 1'b0, 16'h0200, 16'h0000);
    adv(6);
    rst    = 1'b1;
    req[0] = 1'b0;
    adv(1);
    rst    = 1'b0;
    adv(15);

    // Pointer back at 0 after reset: port0 first, then port1
    adv(1); s = cyc;
    push_fill(0, 16'h0300, s, 0);
    push_fill(1, 16'h0404, s + 13, 0);
    drive(0, 1'b0, 16'h0300, 16'h0000);
    drive(1, 1'b0, 16'h0404, 16'h0000);
    wait_done(2'b11); adv(8);

    tb_end = 1'b1;
  end

endmodule
